// File: rtl/dn_router.sv
// Download-stream router: forwards ioctl bytes to the core address space,
// tracks per-transfer byte count/checksum and holds ROM-class targets in reset.
module dn_router #(
    parameter int unsigned ADDR_W        = 17,
    parameter int unsigned ROM_IDX_LIMIT = 2,
    parameter int unsigned HOLD_CYCLES   = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic [7:0]        dn_index,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum,
    output logic              overflow
);

    localparam int unsigned    BC_W      = ADDR_W + 1;
    localparam logic [BC_W-1:0] BC_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [8:0]     ROM_LIM   = 9'(ROM_IDX_LIMIT);
    localparam logic [7:0]     HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } state_t;

    state_t     state;
    logic       download_q;
    logic [7:0] hold_cnt;

    logic rise_c;
    logic start_c;
    logic addr_ok_c;
    logic rom_c;

    assign rise_c    = ioctl_download & ~download_q;
    assign start_c   = rise_c & ((state == IDLE) | (state == HOLD));
    assign addr_ok_c = (ioctl_addr[24:ADDR_W] == '0);
    assign rom_c     = ({1'b0, ioctl_index} < ROM_LIM);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            download_q <= 1'b0;
            hold_cnt   <= '0;
            dn_addr    <= '0;
            dn_data    <= '0;
            dn_wr      <= 1'b0;
            dn_index   <= '0;
            core_reset <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_count <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
        end else begin
            download_q <= ioctl_download;
            dn_wr      <= 1'b0;
            done       <= 1'b0;

            // A new transfer start wins over HOLD countdown, suppressing done.
            if (start_c) begin
                state      <= LOAD;
                dn_index   <= ioctl_index;
                byte_count <= '0;
                checksum   <= '0;
                overflow   <= 1'b0;
                busy       <= 1'b1;
                core_reset <= rom_c;
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    LOAD: begin
                        if (ioctl_wr) begin
                            if (addr_ok_c) begin
                                dn_wr    <= 1'b1;
                                dn_addr  <= ioctl_addr[ADDR_W-1:0];
                                dn_data  <= ioctl_dout;
                                checksum <= checksum + ioctl_dout;
                                if (byte_count != BC_MAX)
                                    byte_count <= byte_count + BC_W'(1);
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                        if (!ioctl_download) begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == 8'd0) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            core_reset <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dn_router.sv
// Directed bench for dn_router: ROM/non-ROM transfers, range drop, long burst,
// re-rise during hold and mid-transfer reset.
module tb_dn_router;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned HOLD   = 16;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_index;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic              dn_wr;
    logic [7:0]        dn_index;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   byte_count;
    logic [7:0]        checksum;
    logic              overflow;

    int passed = 0;
    int total  = 0;
    int wr_pulses = 0;
    int base;
    logic flag;

    dn_router #(.ADDR_W(ADDR_W), .ROM_IDX_LIMIT(2), .HOLD_CYCLES(HOLD)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .dn_index(dn_index),
        .core_reset(core_reset), .busy(busy), .done(done),
        .byte_count(byte_count), .checksum(checksum), .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (dn_wr) wr_pulses++;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && busy; i++) step();
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
        step(); step();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd0);
        check("rst_dn_wr", 32'(dn_wr), 32'd0);
        check("rst_outputs", {7'd0, dn_addr, dn_data}, 32'd0);
        check("rst_counts", {15'd0, byte_count, checksum, overflow, done}, 32'd0);

        // ROM index 0, four writes
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        step();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_core_reset", 32'(core_reset), 32'd1);
        for (int i = 0; i < 4; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i + 1);
            step();
            check("t1_dn_wr", 32'(dn_wr), 32'd1);
            check("t1_dn_addr", 32'(dn_addr), 32'(i));
            check("t1_dn_data", 32'(dn_data), 32'(i + 1));
        end
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        flag = 1'b1;
        for (int i = 0; i < HOLD; i++) begin
            step();
            if (!core_reset || done) flag = 1'b0;
        end
        check("t1_hold_core_reset", 32'(flag), 32'd1);
        step();
        check("t1_core_reset_fall", 32'(core_reset), 32'd0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_byte_count", 32'(byte_count), 32'd4);
        check("t1_checksum", 32'(checksum), 32'h0A);
        check("t1_overflow", 32'(overflow), 32'd0);
        step();
        check("t1_done_pulse", 32'(done), 32'd0);

        // Non-ROM index 3, boundary address and out-of-range drop
        ioctl_index = 8'd3; ioctl_download = 1'b1;
        step();
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_dn_index", 32'(dn_index), 32'd3);
        ioctl_wr = 1'b1; ioctl_addr = 25'h1FFFF; ioctl_dout = 8'hFF;
        step();
        check("t2_dn_wr", 32'(dn_wr), 32'd1);
        check("t2_dn_addr", 32'(dn_addr), 32'h1FFFF);
        ioctl_addr = 25'h20000; ioctl_dout = 8'h55;
        step();
        check("t2_drop_dn_wr", 32'(dn_wr), 32'd0);
        check("t2_overflow", 32'(overflow), 32'd1);
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        flag = 1'b1;
        for (int i = 0; i < HOLD + 1; i++) begin
            if (core_reset) flag = 1'b0;
            step();
        end
        check("t2_no_core_reset", 32'(flag), 32'd1);
        check("t2_done", 32'(done), 32'd1);
        check("t2_byte_count", 32'(byte_count), 32'd1);
        check("t2_checksum", 32'(checksum), 32'hFF);

        // 300 back-to-back writes, last one coincides with download falling
        ioctl_index = 8'd5; ioctl_download = 1'b1;
        step();
        base = wr_pulses;
        for (int i = 0; i < 300; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'h01;
            if (i == 299) ioctl_download = 1'b0;
            step();
        end
        check("t3_last_dn_wr", 32'(dn_wr), 32'd1);
        check("t3_last_dn_addr", 32'(dn_addr), 32'd299);
        ioctl_wr = 1'b0;
        step();
        check("t3_pulses", 32'(wr_pulses - base), 32'd300);
        check("t3_byte_count", 32'(byte_count), 32'd300);
        check("t3_checksum", 32'(checksum), 32'h2C);
        wait_idle();
        check("t3_done", 32'(done), 32'd1);

        // Write during IDLE is ignored
        base = wr_pulses;
        ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'h33;
        step();
        ioctl_wr = 1'b0;
        step();
        check("idle_no_wr", 32'(wr_pulses - base), 32'd0);
        check("idle_count_hold", 32'(byte_count), 32'd300);

        // Re-rise three cycles into HOLD
        ioctl_index = 8'd1; ioctl_download = 1'b1;
        step();
        ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h07;
        step();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!core_reset || done) flag = 1'b0;
        end
        ioctl_download = 1'b1;
        step();
        if (!core_reset || done) flag = 1'b0;
        check("t4_continuous", 32'(flag), 32'd1);
        check("t4_byte_count", 32'(byte_count), 32'd0);
        check("t4_checksum", 32'(checksum), 32'd0);

        // Reset mid-LOAD with download still high
        ioctl_wr = 1'b1; ioctl_addr = 25'd2; ioctl_dout = 8'h09;
        step();
        ioctl_wr = 1'b0;
        step();
        check("t5_pre_count", 32'(byte_count), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_rst_state", {25'd0, busy, core_reset, dn_wr, done, overflow, (byte_count != 0), (dn_index != 0)}, 32'd0);
        step();
        check("t5_reload_busy", 32'(busy), 32'd1);
        check("t5_reload_core_reset", 32'(core_reset), 32'd1);
        check("t5_reload_index", 32'(dn_index), 32'd1);
        check("t5_reload_count", 32'(byte_count), 32'd0);
        ioctl_download = 1'b0;
        wait_idle();
        check("t5_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
